win_scan_seq: RTL and testbench

//  Sequential, parametrised five-in-a-row judge for an NxN board. On start it snapshots one player's

---
 rtl/win_scan_seq.sv | 189 ++++++++++++++++++
 tb/tb_win_scan_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/win_scan_seq.sv
// win_scan_seq: sequential five-in-a-row judge for an NxN board.
// Starting at the last move, it walks outward one cell per clock in each of
// four directions (horizontal, vertical, diagonal, anti-diagonal). It reports
// the win flag, the winning direction and the run length.
// Optional feature macro: WIN_EXACT_EN. When it is defined, only a run of
// exactly K stones wins (an overline does not), and each side is allowed to
// count up to K stones.
module win_scan_seq #(
  parameter  int N  = 15,
  parameter  int K  = 5,
  localparam int CW = $clog2(N),
  localparam int LW = $clog2(2*K+1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [CW-1:0]  row,
  input  logic [CW-1:0]  col,
  input  logic [N*N-1:0] board,
  output logic           busy,
  output logic           done,
  output logic           win,
  output logic [1:0]     win_dir,
  output logic [LW-1:0]  run_len,
  output logic           err
);

  localparam int IW = $clog2(N*N);
`ifdef WIN_EXACT_EN
  localparam int LIM = K;
`else
  localparam int LIM = K-1;
`endif

  typedef enum logic [2:0] {IDLE, SCAN_NEG, SCAN_POS, EVAL, DONE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  org_r, org_c, cur_r, cur_c, nxt_r, nxt_c;
  logic [N*N-1:0] board_q;
  logic           bad;
  logic [1:0]     dir;
  logic [LW-1:0]  cnt_neg, cnt_pos, cnt_cur, cnt_inc, run_now;
  logic           neg, r_fwd, r_bwd, c_fwd;
  logic           r_inc, r_dec, c_inc, c_dec;
  logic           in_bounds, hit, side_end, win_now;
  logic [IW-1:0]  idx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Step geometry: the next cell on the current side, its bounds test and stone test
  always_comb begin
    neg   = (state == SCAN_NEG);
    r_fwd = (dir == 2'd1) || (dir == 2'd2);
    r_bwd = (dir == 2'd3);
    c_fwd = (dir != 2'd1);
    // The negative side simply mirrors the direction vector.
    r_inc = neg ? r_bwd : r_fwd;
    r_dec = neg ? r_fwd : r_bwd;
    c_inc = !neg && c_fwd;
    c_dec = neg && c_fwd;
    in_bounds = !(r_inc && (cur_r == CW'(N-1))) && !(r_dec && (cur_r == '0)) &&
                !(c_inc && (cur_c == CW'(N-1))) && !(c_dec && (cur_c == '0));
    nxt_r = cur_r;
    if (r_inc) nxt_r = cur_r + CW'(1);
    if (r_dec) nxt_r = cur_r - CW'(1);
    nxt_c = cur_c;
    if (c_inc) nxt_c = cur_c + CW'(1);
    if (c_dec) nxt_c = cur_c - CW'(1);
    idx      = IW'(nxt_r) * IW'(N) + IW'(nxt_c);
    hit      = in_bounds && board_q[idx];
    cnt_cur  = neg ? cnt_neg : cnt_pos;
    cnt_inc  = cnt_cur + LW'(1);
    side_end = !hit || (cnt_inc == LW'(LIM));
    run_now  = LW'(1) + cnt_neg + cnt_pos;
`ifdef WIN_EXACT_EN
    win_now  = (run_now == LW'(K));
`else
    win_now  = (run_now >= LW'(K));
`endif
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = SCAN_NEG;
      SCAN_NEG: begin
        if (bad)           state_nxt = DONE;
        else if (side_end) state_nxt = SCAN_POS;
      end
      SCAN_POS: if (side_end) state_nxt = EVAL;
      EVAL:     begin
        if (win_now || (dir == 2'd3)) state_nxt = DONE;
        else                          state_nxt = SCAN_NEG;
      end
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath: snapshot on accept, per-side counting, per-direction evaluation
  always_ff @(posedge clk) begin
    if (rst) begin
      org_r   <= '0;
      org_c   <= '0;
      cur_r   <= '0;
      cur_c   <= '0;
      board_q <= '0;
      bad     <= 1'b0;
      dir     <= '0;
      cnt_neg <= '0;
      cnt_pos <= '0;
      win     <= 1'b0;
      win_dir <= '0;
      run_len <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          org_r   <= row;
          org_c   <= col;
          cur_r   <= row;
          cur_c   <= col;
          board_q <= board;
          bad     <= ({1'b0, row} >= (CW+1)'(N)) || ({1'b0, col} >= (CW+1)'(N));
          dir     <= '0;
          cnt_neg <= '0;
          cnt_pos <= '0;
          win     <= 1'b0;
          win_dir <= '0;
          run_len <= '0;
          err     <= 1'b0;
        end
        SCAN_NEG: begin
          if (bad) begin
            err <= 1'b1;
          end else begin
            if (hit) begin
              cnt_neg <= cnt_inc;
              cur_r   <= nxt_r;
              cur_c   <= nxt_c;
            end
            // Rewind to the origin so the positive side starts from the move.
            if (side_end) begin
              cur_r <= org_r;
              cur_c <= org_c;
            end
          end
        end
        SCAN_POS: begin
          if (hit) begin
            cnt_pos <= cnt_inc;
            cur_r   <= nxt_r;
            cur_c   <= nxt_c;
          end
          if (side_end) begin
            cur_r <= org_r;
            cur_c <= org_c;
          end
        end
        EVAL: begin
          // run_len tracks the best run seen; a win overrides it with the winning run.
          if (run_now > run_len) run_len <= run_now;
          if (win_now) begin
            win     <= 1'b1;
            win_dir <= dir;
            run_len <= run_now;
          end else if (dir != 2'd3) begin
            dir     <= dir + 2'd1;
            cnt_neg <= '0;
            cnt_pos <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_win_scan_seq.sv
// Directed bench for win_scan_seq (N=15, K=5). Expected results are queued
// when a request is driven and are popped and compared when done pulses.
module tb_win_scan_seq;
  localparam int N  = 15;
  localparam int K  = 5;
  localparam int CW = $clog2(N);
  localparam int LW = $clog2(2*K+1);

  logic           clk = 1'b0;
  logic           rst, start;
  logic [CW-1:0]  row, col;
  logic [N*N-1:0] board;
  logic           busy, done, win, err;
  logic [1:0]     win_dir;
  logic [LW-1:0]  run_len;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic win;
    int   dir;
    int   len;
    logic err;
    int   lat;
  } exp_t;
  exp_t sb[$];

  win_scan_seq #(.N(N), .K(K)) dut (
    .clk(clk), .rst(rst), .start(start), .row(row), .col(col), .board(board),
    .busy(busy), .done(done), .win(win), .win_dir(win_dir), .run_len(run_len), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic logic [N*N-1:0] put(input logic [N*N-1:0] b, input int r, input int c);
    logic [N*N-1:0] t;
    t = b;
    t[r*N+c] = 1'b1;
    return t;
  endfunction

  // Drive one request, wait for done within a bound, pop and compare.
  // elat == 0 skips the latency comparison; poke issues a start mid-scan.
  task automatic run_case(input string tag, input int r, input int c, input logic [N*N-1:0] b,
                          input logic ew, input int edir, input int elen, input logic eerr,
                          input int elat, input logic poke);
    exp_t e;
    int   lat;
    @(negedge clk);
    sb.push_back('{ew, edir, elen, eerr, elat});
    row = CW'(r); col = CW'(c); board = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      if (poke && lat == 4) begin
        start = 1'b1; row = '0; col = '0; board = '1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    e = sb.pop_front();
    chk({tag, " done_seen"}, 32'(done), 32'(1));
    if (e.lat > 0) chk({tag, " latency"}, 32'(lat), 32'(e.lat));
    chk({tag, " win"}, 32'(win), 32'(e.win));
    if (e.win) chk({tag, " win_dir"}, 32'(win_dir), 32'(e.dir));
    chk({tag, " run_len"}, 32'(run_len), 32'(e.len));
    chk({tag, " err"}, 32'(err), 32'(e.err));
    chk({tag, " busy_at_done"}, 32'(busy), 32'(1));
    @(negedge clk);
    chk({tag, " done_pulse"}, 32'(done), 32'(0));
    chk({tag, " idle_after"}, 32'(busy), 32'(0));
    chk({tag, " win_held"}, 32'(win), 32'(e.win));
  endtask

  initial begin
    logic [N*N-1:0] b;
    rst = 1'b1; start = 1'b0; row = '0; col = '0; board = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", 32'(busy), 32'(0));
    chk("rst done", 32'(done), 32'(0));
    chk("rst win", 32'(win), 32'(0));
    chk("rst err", 32'(err), 32'(0));
    chk("rst dir", 32'(win_dir), 32'(0));
    chk("rst len", 32'(run_len), 32'(0));
    rst = 1'b0;

    // Empty board: 4 directions x 3 cycles, with a start ignored mid-scan.
    run_case("empty", 7, 7, '0, 1'b0, 0, 1, 1'b0, 13, 1'b1);

    // Origin bit is ignored.
    b = put('0, 7, 7);
    run_case("origin", 7, 7, b, 1'b0, 0, 1, 1'b0, 13, 1'b0);

    // Horizontal five ending at the move.
    b = '0;
    for (int i = 3; i <= 6; i++) b = put(b, 7, i);
    run_case("horiz", 7, 7, b, 1'b1, 0, 5, 1'b0, 0, 1'b0);

    // Horizontal and vertical both win: lowest direction reported.
    for (int i = 3; i <= 6; i++) b = put(b, i, 7);
    run_case("lowest", 7, 7, b, 1'b1, 0, 5, 1'b0, 0, 1'b0);

    // Anti-diagonal into row 0 corner region.
    b = '0;
    b = put(b, 4, 0); b = put(b, 3, 1); b = put(b, 2, 2); b = put(b, 1, 3);
    run_case("anti", 0, 4, b, 1'b1, 3, 5, 1'b0, 0, 1'b0);

    // Vertical up to the bottom edge.
    b = '0;
    for (int i = 10; i <= 13; i++) b = put(b, i, 0);
    run_case("vert", 14, 0, b, 1'b1, 1, 5, 1'b0, 0, 1'b0);

    // No wrap from column 0 to the previous row's last column.
    b = '0;
    for (int i = 11; i <= 14; i++) b = put(b, 6, i);
    run_case("nowrap", 7, 0, b, 1'b0, 0, 1, 1'b0, 0, 1'b0);

    // Corner on an empty board.
    run_case("corner", 14, 14, '0, 1'b0, 0, 1, 1'b0, 13, 1'b0);

    // Diagonal run of four: no win, maximum run reported.
    b = '0;
    b = put(b, 4, 4); b = put(b, 5, 5); b = put(b, 6, 6);
    run_case("diag4", 7, 7, b, 1'b0, 0, 4, 1'b0, 0, 1'b0);

    // Overline of seven.
    b = '0;
    for (int i = 2; i <= 8; i++) b = put(b, 7, i);
`ifdef WIN_EXACT_EN
    run_case("overline", 7, 5, b, 1'b0, 0, 7, 1'b0, 0, 1'b0);
`else
    run_case("overline", 7, 5, b, 1'b1, 0, 7, 1'b0, 0, 1'b0);
`endif

    // Invalid coordinates.
    run_case("bad_row", 15, 3, '1, 1'b0, 0, 0, 1'b1, 2, 1'b0);
    run_case("bad_col", 3, 15, '1, 1'b0, 0, 0, 1'b1, 2, 1'b0);

    // Reset in the middle of a scan: no done, everything cleared.
    b = '0;
    for (int i = 3; i <= 6; i++) b = put(b, 7, i);
    @(negedge clk);
    row = CW'(7); col = CW'(7); board = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst done", 32'(done), 32'(0));
    end
    chk("midrst busy", 32'(busy), 32'(0));
    chk("midrst win", 32'(win), 32'(0));
    chk("midrst len", 32'(run_len), 32'(0));
    chk("midrst err", 32'(err), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("midrst idle", 32'(busy), 32'(0));
    run_case("after_rst", 7, 7, b, 1'b1, 0, 5, 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
